// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame controller: FSM encoding,
// header geometry and the legal-size check applied to an incoming header.
package sobel_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_PIXELS = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam int HDR_BYTES = 4;
  localparam int MIN_DIM   = 3;

  function automatic logic size_ok(input logic [15:0] w, input logic [15:0] h,
                                   input int max_w);
    return (32'(w) >= 32'(MIN_DIM)) && (32'(w) <= 32'(max_w)) &&
           (32'(h) >= 32'(MIN_DIM));
  endfunction

endpackage

// File: rtl/sobel_timeout_counter.sv
// Idle watchdog: counts enabled cycles without activity and pulses tc for one
// cycle when LIMIT consecutive idle cycles have elapsed.
module sobel_timeout_counter #(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // The terminal cycle is the LIMIT-th idle cycle, so tc fires while cnt holds LIMIT-1.
  assign tc = en && !clr && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame controller between a UART byte stream and a Sobel core: parses the
// 4-byte size header, replays it to the core, forwards pixels and returns results.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int MAX_WIDTH      = 2048,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_valid,
  output logic [DATA_BITS-1:0] core_data,
  output logic                 core_valid,
  input  logic [DATA_BITS-1:0] core_out_data,
  input  logic                 core_out_valid,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_size,
  output logic                 err_timeout,
  output logic                 err_overrun,
  output logic [15:0]          width,
  output logic [15:0]          height,
  output logic [2:0]           state,
  output logic [31:0]          in_count,
  output logic [31:0]          out_count
);

  // Handshakes: rx_valid, core_valid and core_out_valid are one-cycle strobes
  // with no back-pressure; tx_data is held with tx_valid high until a cycle
  // with tx_valid && tx_ready, which is the transfer.

  state_t                 st;
  logic [1:0]             hdr_cnt;
  logic [2:0]             rep_cnt;
  logic                   hold_valid;
  logic [DATA_BITS-1:0]   hold_data;
  logic [31:0]            expected;
  logic [15:0]            h_new;
  logic [7:0]             rep_byte;
  logic                   tmo;
  logic                   tmo_en;

  assign h_new      = {rx_data[7:0], height[7:0]};
  assign busy       = (st != S_IDLE);
  assign frame_done = (st == S_DONE);
  assign state      = st;
  assign tmo_en     = (st == S_HDR) || (st == S_PIXELS) || (st == S_DRAIN);

  always_comb begin
    rep_byte = width[7:0];
    case (rep_cnt[1:0])
      2'd1:    rep_byte = width[15:8];
      2'd2:    rep_byte = height[7:0];
      2'd3:    rep_byte = height[15:8];
      default: rep_byte = width[7:0];
    endcase
  end

  sobel_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk (clk),
    .rst (rst),
    .en  (tmo_en),
    .clr (rx_valid || core_out_valid),
    .tc  (tmo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= S_IDLE;
      hdr_cnt     <= '0;
      rep_cnt     <= '0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      expected    <= '0;
      in_count    <= '0;
      out_count   <= '0;
      core_data   <= '0;
      core_valid  <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      err_size    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      width       <= '0;
      height      <= '0;
    end else begin
      core_valid <= 1'b0;
      if (err_clr) begin
        err_size    <= 1'b0;
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end

      // Result path: a single tx register; a new byte while it is stuck is lost.
      if (st == S_ERROR) begin
        tx_valid <= 1'b0;
      end else begin
        if (tx_valid && tx_ready) tx_valid <= 1'b0;
        if ((st == S_PIXELS || st == S_DRAIN) && core_out_valid) begin
          if (tx_valid && !tx_ready) begin
            err_overrun <= 1'b1;
          end else begin
            tx_data   <= core_out_data;
            tx_valid  <= 1'b1;
            out_count <= out_count + 32'd1;
          end
        end
      end

      case (st)
        S_IDLE: begin
          if (rx_valid) begin
            width[7:0] <= rx_data[7:0];
            hdr_cnt    <= 2'd1;
            st         <= S_HDR;
          end
        end
        S_HDR: begin
          if (rx_valid) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd1: width[15:8] <= rx_data[7:0];
              2'd2: height[7:0] <= rx_data[7:0];
              default: begin
                height[15:8] <= rx_data[7:0];
                if (size_ok(width, h_new, MAX_WIDTH)) begin
                  // Replay starts on this edge with the first header byte.
                  expected   <= 32'(width) * 32'(h_new);
                  core_valid <= 1'b1;
                  core_data  <= DATA_BITS'(width[7:0]);
                  rep_cnt    <= 3'd1;
                  hold_valid <= 1'b0;
                  st         <= S_PIXELS;
                end else begin
                  err_size <= 1'b1;
                  st       <= S_ERROR;
                end
              end
            endcase
          end
        end
        S_PIXELS: begin
          if (rep_cnt < 3'(HDR_BYTES)) begin
            core_valid <= 1'b1;
            core_data  <= DATA_BITS'(rep_byte);
            rep_cnt    <= rep_cnt + 3'd1;
            if (rx_valid && !hold_valid) begin
              hold_valid <= 1'b1;
              hold_data  <= rx_data;
            end
          end else if (hold_valid || rx_valid) begin
            // The held byte goes first; a byte arriving alongside it slips into the hold.
            core_valid <= 1'b1;
            core_data  <= hold_valid ? hold_data : rx_data;
            hold_valid <= hold_valid && rx_valid;
            hold_data  <= rx_data;
            in_count   <= in_count + 32'd1;
            if (in_count + 32'd1 == expected) begin
              hold_valid <= 1'b0;
              st         <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (out_count == expected && !tx_valid) st <= S_DONE;
        end
        S_DONE: begin
          st        <= S_IDLE;
          hdr_cnt   <= '0;
          rep_cnt   <= '0;
          in_count  <= '0;
          out_count <= '0;
        end
        default: begin
          hold_valid <= 1'b0;
          if (err_clr) begin
            st        <= S_IDLE;
            hdr_cnt   <= '0;
            rep_cnt   <= '0;
            in_count  <= '0;
            out_count <= '0;
          end
        end
      endcase

      if (tmo) begin
        err_timeout <= 1'b1;
        st          <= S_ERROR;
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl: scoreboards for the core-side and
// tx-side byte streams plus per-scenario tasks.
module tb_sobel_frame_ctrl;

  localparam int DW   = 8;
  localparam int MAXW = 2048;
  localparam int TMO  = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] core_data;
  logic          core_valid;
  logic [DW-1:0] core_out_data;
  logic          core_out_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          err_clr;
  logic          busy;
  logic          frame_done;
  logic          err_size;
  logic          err_timeout;
  logic          err_overrun;
  logic [15:0]   width;
  logic [15:0]   height;
  logic [2:0]    state;
  logic [31:0]   in_count;
  logic [31:0]   out_count;

  sobel_frame_ctrl #(
    .DATA_BITS      (DW),
    .MAX_WIDTH      (MAXW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .core_data      (core_data),
    .core_valid     (core_valid),
    .core_out_data  (core_out_data),
    .core_out_valid (core_out_valid),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .err_clr        (err_clr),
    .busy           (busy),
    .frame_done     (frame_done),
    .err_size       (err_size),
    .err_timeout    (err_timeout),
    .err_overrun    (err_overrun),
    .width          (width),
    .height         (height),
    .state          (state),
    .in_count       (in_count),
    .out_count      (out_count)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [DW-1:0] tx_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  logic [DW-1:0] mon_e;
  int            mon_c;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (core_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL core_unexpected: got %02h at cycle %0d, nothing expected", core_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (core_data !== mon_e || (mon_c >= 0 && mon_c != cyc)) begin
          n_err++;
          $display("FAIL core_stream: got %02h at cycle %0d, expected %02h at cycle %0d",
                   core_data, cyc, mon_e, mon_c);
        end
      end
    end
    if (tx_valid && tx_ready) begin
      n_vec++;
      if (tx_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got %02h at cycle %0d, nothing expected", tx_data, cyc);
      end else begin
        mon_e = tx_q.pop_front();
        if (tx_data !== mon_e) begin
          n_err++;
          $display("FAIL tx_stream: got %02h, expected %02h", tx_data, mon_e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input int gap, output int c);
    rx_valid = 1'b1;
    rx_data  = b;
    c        = cyc;
    sync();
    rx_valid = 1'b0;
    repeat (gap - 1) sync();
  endtask

  task automatic core_emit(input logic [7:0] b, input int gap, input bit expect_tx);
    core_out_valid = 1'b1;
    core_out_data  = b;
    if (expect_tx) tx_q.push_back(b);
    sync();
    core_out_valid = 1'b0;
    repeat (gap - 1) sync();
  endtask

  task automatic send_header(input logic [15:0] w, input logic [15:0] h, input bit ok,
                             output int n);
    int c;
    send_rx(w[7:0], 2, c);
    send_rx(w[15:8], 2, c);
    send_rx(h[7:0], 2, c);
    send_rx(h[15:8], 1, n);
    if (ok) begin
      exp_q.push_back(w[7:0]);  exp_cyc_q.push_back(n + 1);
      exp_q.push_back(w[15:8]); exp_cyc_q.push_back(n + 2);
      exp_q.push_back(h[7:0]);  exp_cyc_q.push_back(n + 3);
      exp_q.push_back(h[15:8]); exp_cyc_q.push_back(n + 4);
    end
  endtask

  // First pixel lands inside the replay window and must appear right after it.
  task automatic send_pixels(input int count, input int n, output int last_c);
    logic [7:0] p;
    int         gap;
    int         c;
    for (int i = 0; i < count; i++) begin
      p   = 8'($urandom_range(0, 255));
      gap = (i == 0) ? 4 : $urandom_range(1, 3);
      exp_q.push_back(p);
      exp_cyc_q.push_back((cyc + 1 <= n + 4) ? n + 5 : cyc + 1);
      send_rx(p, gap, c);
      last_c = c;
    end
  endtask

  task automatic run_frame(input logic [15:0] w, input logic [15:0] h, input int extras);
    int n, c, d0, total;
    bit got;
    sync();
    d0    = done_cnt;
    total = int'(w) * int'(h);
    send_header(w, h, 1'b1, n);
    fork
      begin
        send_pixels(total, n, c);
        for (int i = 0; i < extras; i++) send_rx(8'($urandom_range(0, 255)), 2, c);
      end
      begin
        repeat (20) sync();
        for (int i = 0; i < total; i++) begin
          if (i == total - 1) begin
            n_vec++;
            if (done_cnt != d0 || busy !== 1'b1) begin
              n_err++;
              $display("FAIL early_done: done pulses %0d busy %0b before last output, expected 0 and 1",
                       done_cnt - d0, busy);
            end
          end
          core_emit(8'($urandom_range(0, 255)), 3, 1'b1);
        end
      end
    join
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL frame_done: no pulse within 40 cycles for %0dx%0d frame", w, h);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || state !== 3'd0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL post_frame: busy %0b state %0d frame_done %0b, expected 0 0 0",
               busy, state, frame_done);
    end
    sync();
    n_vec++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0 || tx_q.size() != 0) begin
      n_err++;
      $display("FAIL frame_totals: done pulses %0d core left %0d tx left %0d, expected 1 0 0",
               done_cnt - d0, exp_q.size(), tx_q.size());
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    sync();
    err_clr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({core_valid, tx_valid, frame_done, busy, err_size, err_timeout, err_overrun} !== 7'd0 ||
        width !== 16'd0 || height !== 16'd0 || state !== 3'd0 ||
        core_data !== 8'd0 || tx_data !== 8'd0 || in_count !== 32'd0 || out_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: flags %b w %0d h %0d state %0d cd %02h td %02h in %0d out %0d, expected all 0",
               {core_valid, tx_valid, frame_done, busy, err_size, err_timeout, err_overrun},
               width, height, state, core_data, tx_data, in_count, out_count);
    end
    sync();
    rst = 1'b0;
    repeat (2) sync();
  endtask

  task automatic test_frame();
    run_frame(16'd5, 16'd4, 0);
    n_vec++;
    if (width !== 16'd5 || height !== 16'd4) begin
      n_err++;
      $display("FAIL dims: got %0dx%0d, expected 5x4", width, height);
    end
  endtask

  task automatic test_size_err();
    logic [15:0] bad_w[3] = '{16'd1, 16'd2049, 16'd5};
    logic [15:0] bad_h[3] = '{16'd4, 16'd4, 16'd2};
    int n, c;
    for (int i = 0; i < 3; i++) begin
      sync();
      send_header(bad_w[i], bad_h[i], 1'b0, n);
      @(negedge clk);
      n_vec++;
      if (err_size !== 1'b1 || state !== 3'd5 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL size_err %0dx%0d: err_size %0b state %0d busy %0b, expected 1 5 1",
                 bad_w[i], bad_h[i], err_size, state, busy);
      end
      sync();
      send_rx(8'h33, 2, c);
      pulse_err_clr();
      @(negedge clk);
      n_vec++;
      if (err_size !== 1'b0 || state !== 3'd0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL size_clr %0dx%0d: err_size %0b state %0d busy %0b, expected 0 0 0",
                 bad_w[i], bad_h[i], err_size, state, busy);
      end
    end
  endtask

  task automatic test_min_frame();
    run_frame(16'd3, 16'd3, 0);
  endtask

  task automatic test_extras();
    run_frame(16'd4, 16'd4, 3);
  endtask

  task automatic test_timeout();
    int n, m, d0;
    sync();
    d0 = done_cnt;
    send_header(16'd4, 16'd4, 1'b1, n);
    send_pixels(7, n, m);
    for (int i = 0; i < 2 * TMO && cyc < m + TMO; i++) @(negedge clk);
    n_vec++;
    if (cyc != m + TMO || err_timeout !== 1'b0 || state !== 3'd2) begin
      n_err++;
      $display("FAIL timeout_early: cycle %0d err_timeout %0b state %0d, expected cycle %0d 0 2",
               cyc - m, err_timeout, state, TMO);
    end
    @(negedge clk);
    n_vec++;
    if (err_timeout !== 1'b1 || state !== 3'd5) begin
      n_err++;
      $display("FAIL timeout_fire: err_timeout %0b state %0d after %0d idle cycles, expected 1 5",
               err_timeout, state, TMO);
    end
    sync();
    pulse_err_clr();
    n_vec++;
    if (err_timeout !== 1'b0 || state !== 3'd0 || done_cnt != d0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout_clr: err_timeout %0b state %0d done pulses %0d core left %0d, expected 0 0 0 0",
               err_timeout, state, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_overrun();
    int n, c, d0;
    bit got;
    sync();
    d0 = done_cnt;
    send_header(16'd4, 16'd4, 1'b1, n);
    send_pixels(16, n, c);
    repeat (3) sync();
    tx_ready = 1'b0;
    core_emit(8'hA5, 1, 1'b1);
    core_emit(8'h5A, 1, 1'b0);
    @(negedge clk);
    n_vec++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || err_overrun !== 1'b1 || out_count !== 32'd1) begin
      n_err++;
      $display("FAIL overrun: tx_valid %0b tx_data %02h err_overrun %0b out_count %0d, expected 1 a5 1 1",
               tx_valid, tx_data, err_overrun, out_count);
    end
    sync();
    tx_ready = 1'b1;
    for (int i = 0; i < 15; i++) core_emit(8'($urandom_range(0, 255)), 2, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    n_vec++;
    if (!got || err_overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_frame: frame_done seen %0b err_overrun %0b, expected 1 1", got, err_overrun);
    end
    sync();
    pulse_err_clr();
    n_vec++;
    if (err_overrun !== 1'b0 || tx_q.size() != 0 || done_cnt != d0 + 1) begin
      n_err++;
      $display("FAIL overrun_clr: err_overrun %0b tx left %0d done pulses %0d, expected 0 0 1",
               err_overrun, tx_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int n, c;
    sync();
    send_header(16'd5, 16'd5, 1'b1, n);
    send_pixels(9, n, c);
    rx_valid = 1'b1;
    rx_data  = 8'hC3;
    sync();
    rx_valid = 1'b0;
    n_vec++;
    if (core_valid !== 1'b1 || core_data !== 8'hC3) begin
      n_err++;
      $display("FAIL pixel10_fwd: core_valid %0b core_data %02h, expected 1 c3", core_valid, core_data);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({core_valid, tx_valid, frame_done, busy, err_size, err_timeout, err_overrun} !== 7'd0 ||
        width !== 16'd0 || height !== 16'd0 || state !== 3'd0 || core_data !== 8'd0 ||
        in_count !== 32'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid: flags %b w %0d h %0d state %0d cd %02h in %0d core left %0d, expected all 0",
               {core_valid, tx_valid, frame_done, busy, err_size, err_timeout, err_overrun},
               width, height, state, core_data, in_count, exp_q.size());
    end
    repeat (3) sync();
    rst = 1'b0;
    repeat (2) sync();
    run_frame(16'd3, 16'd3, 0);
    n_vec++;
    if (width !== 16'd3 || height !== 16'd3) begin
      n_err++;
      $display("FAIL dims_after_reset: got %0dx%0d, expected 3x3", width, height);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst            = 1'b1;
    rx_valid       = 1'b0;
    rx_data        = '0;
    core_out_valid = 1'b0;
    core_out_data  = '0;
    tx_ready       = 1'b1;
    err_clr        = 1'b0;
    test_reset();
    test_frame();
    test_size_err();
    test_min_frame();
    test_extras();
    test_timeout();
    test_overrun();
    test_reset_mid();
    repeat (5) sync();
    n_vec++;
    if (exp_q.size() != 0 || tx_q.size() != 0) begin
      n_err++;
      $display("FAIL final_queues: core left %0d tx left %0d, expected 0 0", exp_q.size(), tx_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
